// File: rtl/gray_sync_decoder.sv
// Gray-count receive stage: synchronises a foreign-domain Gray count, decodes it to binary and
// reports count progress as step deltas over valid/ready. Define GRAY_SYNC_ERR_CHECK_EN to build the multi-bit-change detector.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk_I,
    input  logic             Rst_I,
    input  logic [WIDTH-1:0] Gray_I,
    output logic [WIDTH-1:0] Bin_O,
    output logic [WIDTH-1:0] Delta_O,
    output logic             Valid_O,
    input  logic             Ready_I,
    output logic             Ovf_O,
    output logic             Err_O
);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   sum;

    // NOTE: every synchroniser stage is reset so a reset cannot leak stale foreign-domain counts.
    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= Gray_I;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    // NOTE: each bin_d bit is written on every pass, so no latch can be inferred.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(gs >> i);
    end

    assign step = bin_d - Bin_O;
    assign sum  = {1'b0, Delta_O} + {1'b0, step};

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            state   <= IDLE;
            Bin_O   <= '0;
            Delta_O <= '0;
            Valid_O <= 1'b0;
            Ovf_O   <= 1'b0;
        end else begin
            Bin_O <= bin_d;
            case (state)
                IDLE: begin
                    if (step != '0) begin
                        Delta_O <= step;
                        Valid_O <= 1'b1;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (Ready_I) begin
                        if (step != '0) begin
                            Delta_O <= step;
                        end else begin
                            Valid_O <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        // Unaccepted steps merge into the pending delta; a wrap is remembered.
                        Delta_O <= sum[WIDTH-1:0];
                        if (sum[WIDTH]) Ovf_O <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef GRAY_SYNC_ERR_CHECK_EN
    logic [WIDTH-1:0] gs_prev;
    logic             err_q;

    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            gs_prev <= '0;
            err_q   <= 1'b0;
        end else begin
            gs_prev <= gs;
            if ($countones(gs ^ gs_prev) > 1) err_q <= 1'b1;
        end
    end

    assign Err_O = err_q;
`else
    assign Err_O = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench for gray_sync_decoder: a count-level reference model queues expected transfers,
// a monitor pops them on each handshake and checks per-cycle status outputs.
module tb_gray_sync_decoder;

    localparam int W = 4;
    localparam int S = 2;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] Gray_I = '0;
    logic         Ready_I = 1'b0;
    logic [W-1:0] Bin_O;
    logic [W-1:0] Delta_O;
    logic         Valid_O;
    logic         Ovf_O;
    logic         Err_O;

    int n_total = 0;
    int n_bad   = 0;
    int n_xfer  = 0;
    int sb[$];

`ifdef GRAY_SYNC_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .Clk_I  (clk),
        .Rst_I  (rst),
        .Gray_I (Gray_I),
        .Bin_O  (Bin_O),
        .Delta_O(Delta_O),
        .Valid_O(Valid_O),
        .Ready_I(Ready_I),
        .Ovf_O  (Ovf_O),
        .Err_O  (Err_O)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b ^= g >> s;
        return b % M;
    endfunction

    // Reference model: the count seen locally is the source count delayed by S edges;
    // the pending delta is an unbounded running total of steps since the last accept.
    int pipe[$];
    int m_bin = 0, m_acc = 0, m_gs_prev = 0;
    bit m_valid = 0, m_ovf = 0, m_err = 0;

    initial begin
        repeat (S) pipe.push_back(0);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pipe = {};
                repeat (S) pipe.push_back(0);
                m_bin = 0; m_acc = 0; m_gs_prev = 0;
                m_valid = 0; m_ovf = 0; m_err = 0;
            end else begin
                int gs, b, stp;
                gs = pipe.pop_front();
                pipe.push_back(int'(Gray_I));
                b   = g2b(gs);
                stp = (b - m_bin + M) % M;
                if (m_valid && Ready_I) sb.push_back(m_acc % M);
                if (!m_valid || Ready_I) begin
                    m_acc   = stp;
                    m_valid = (stp != 0);
                end else begin
                    m_acc = m_acc + stp;
                    if (m_acc >= M) m_ovf = 1;
                end
                if (ERR_EN && $countones(gs ^ m_gs_prev) > 1) m_err = 1;
                m_gs_prev = gs;
                m_bin = b;
            end
        end
    end

    // Monitor: samples on the falling edge; a handshake seen here completes at the next rising edge.
    initial begin
        bit           hs = 0;
        logic [W-1:0] hs_delta = '0;
        forever begin
            @(negedge clk);
            if (hs) begin
                check("xfer_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("xfer_delta", hs_delta, sb.pop_front());
                    n_xfer++;
                end
            end
            check("bin", Bin_O, m_bin);
            check("valid", Valid_O, m_valid);
            check("ovf", Ovf_O, m_ovf);
            check("err", Err_O, m_err);
            if (m_valid) check("delta_pend", Delta_O, m_acc % M);
            hs       = Valid_O && Ready_I;
            hs_delta = Delta_O;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        Gray_I  = '0;
        Ready_I = 1'b0;
        rst     = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [W-1:0] cnt;
        int           thresh;

        // Reset with a quiet source.
        cyc(2);
        rst = 1'b0;
        cyc(10);
        check("idle_bin", Bin_O, 0);
        check("idle_valid", Valid_O, 0);
        check("idle_delta", Delta_O, 0);

        // Single step with consumer ready.
        Ready_I = 1'b1;
        Gray_I  = b2g(4'd1);
        cyc(3);
        check("s1_valid", Valid_O, 1);
        check("s1_bin", Bin_O, 1);
        check("s1_delta", Delta_O, 1);
        cyc(1);
        check("s1_drop", Valid_O, 0);

        // Accumulate five steps under backpressure, then accept.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            Gray_I = b2g(W'(k));
            cyc(3);
        end
        check("acc5_delta", Delta_O, 5);
        check("acc5_valid", Valid_O, 1);
        Ready_I = 1'b1;
        cyc(1);
        Ready_I = 1'b0;
        check("acc5_done", Valid_O, 0);

        // Seventeen steps across the wrap point overflow the accumulator.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            Gray_I = b2g(W'(k));
            cyc(1);
        end
        cyc(3);
        check("wrap_ovf", Ovf_O, 1);
        check("wrap_delta", Delta_O, 1);
        check("wrap_bin", Bin_O, 1);
        check("wrap_err", Err_O, 0);

        // Two-bit Gray jump.
        do_reset();
        Gray_I = 4'b0011;
        cyc(3);
        check("jump_err", Err_O, ERR_EN);
        cyc(5);
        check("jump_err_sticky", Err_O, ERR_EN);

        // Reset while a delta of 3 is pending.
        do_reset();
        Gray_I = b2g(4'd3);
        cyc(3);
        check("mid_delta", Delta_O, 3);
        check("mid_valid", Valid_O, 1);
        Gray_I = '0;
        rst    = 1'b1;
        #1;
        check("rst_valid", Valid_O, 0);
        check("rst_delta", Delta_O, 0);
        check("rst_bin", Bin_O, 0);
        check("rst_ovf", Ovf_O, 0);
        cyc(1);
        rst = 1'b0;
        cyc(5);
        check("post_rst_valid", Valid_O, 0);

        // Randomised count progress with varying consumer readiness.
        do_reset();
        cnt    = '0;
        thresh = 50;
        for (int c = 0; c < 600; c++) begin
            int r;
            if (c % 20 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thresh = 0;
                    1:       thresh = 30;
                    default: thresh = 90;
                endcase
            end
            r = $urandom_range(0, 9);
            if (r < 5) cnt = cnt + 1'b1;
            else if (r == 9) cnt = cnt + W'($urandom_range(2, 5));
            Gray_I  = b2g(cnt);
            Ready_I = ($urandom_range(0, 99) < thresh);
            cyc(1);
        end

        // Drain outstanding transfers.
        Ready_I = 1'b1;
        cyc(8);
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("xfers_seen", (n_xfer > 10), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
